// File: rtl/bus_fifo_pack.sv
// Packing FIFO: 64-bit lanes in, 128-bit beats out (older lane in the low half).
// A flush lets a trailing odd lane leave as a zero-padded beat.
module bus_fifo_pack #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic [63:0]                write_data,
  input  logic                       read_en,
  output logic [127:0]               read_data,
  output logic                       read_data_valid,
  output logic                       read_ready,
  input  logic                       flush,
  output logic                       fifo_full,
  output logic                       fifo_half_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     word_count,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] write_ptr;
  logic [AW-1:0] read_ptr;
  logic [AW-1:0] read_ptr_hi;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          flush_pending;
  logic          flush_pending_next;
  logic          wr_acc;
  logic          rd_acc;
  logic          pad;
  logic [63:0]   lane_lo;
  logic [63:0]   lane_hi;

  assign fifo_full      = (count == CW'(DEPTH));
  assign fifo_half_full = (count >= CW'(DEPTH / 2));
  assign fifo_empty     = (count == '0);
  assign word_count     = count;

  assign read_ready = (count >= CW'(2)) || ((count == CW'(1)) && flush_pending);
  assign wr_acc     = write_en && !fifo_full;
  assign rd_acc     = read_en && read_ready;
  assign pad        = (count == CW'(1));

  // Both read addresses see pre-edge contents, so a same-cycle write never feeds the pop.
  assign read_ptr_hi = read_ptr + AW'(1);
  assign lane_lo     = mem[read_ptr];
  assign lane_hi     = mem[read_ptr_hi];

  always_comb begin
    count_next = count;
    if (wr_acc)
      count_next = count_next + CW'(1);
    if (rd_acc)
      count_next = count_next - (pad ? CW'(1) : CW'(2));
  end

  always_comb begin
    flush_pending_next = flush_pending;
    if (count_next == '0)
      flush_pending_next = 1'b0;
    else if (flush)
      flush_pending_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[write_ptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_ptr       <= '0;
      read_ptr        <= '0;
      count           <= '0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      flush_pending   <= 1'b0;
      overflow_err    <= 1'b0;
      underflow_err   <= 1'b0;
    end else begin
      count           <= count_next;
      flush_pending   <= flush_pending_next;
      read_data_valid <= rd_acc;
      if (wr_acc)
        write_ptr <= write_ptr + AW'(1);
      if (rd_acc) begin
        read_ptr  <= read_ptr + (pad ? AW'(1) : AW'(2));
        read_data <= pad ? {64'h0, lane_lo} : {lane_hi, lane_lo};
      end
      if (write_en && fifo_full)
        overflow_err <= 1'b1;
      if (read_en && !read_ready)
        underflow_err <= 1'b1;
    end
  end

endmodule
